// File: rtl/serial_signmag_pkg.sv
// rtl/serial_signmag_pkg.sv - shared state encoding and default word width for the sign-magnitude decoder
package serial_signmag_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      EMIT = 2'd2
   } state_t;

endpackage

// File: rtl/serial_negate_cell.sv
// rtl/serial_negate_cell.sv - bit-serial two's-complement negate (copy up to first 1, invert afterwards)
module serial_negate_cell (
   input  logic clk,
   input  logic areset_n,
   input  logic clr,
   input  logic en,
   input  logic neg,
   input  logic b,
   output logic z
);

   logic one_seen;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         one_seen <= 1'b0;
      end else if (clr) begin
         one_seen <= 1'b0;
      end else if (en && b) begin
         one_seen <= 1'b1;
      end
   end

   // Mealy: the current bit passes unchanged until a 1 has gone by
   assign z = (neg && one_seen) ? ~b : b;

endmodule

// File: rtl/serial_signmag_decoder.sv
// rtl/serial_signmag_decoder.sv - serial two's-complement to sign-magnitude decoder, optional SIGNMAG_PARALLEL_OUT_EN
module serial_signmag_decoder
   import serial_signmag_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic             out_sign,
   output logic             out_last
`ifdef SIGNMAG_PARALLEL_OUT_EN
   ,
   output logic [WIDTH-1:0] mag_q,
   output logic             mag_valid
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_in;
   logic [CW-1:0]    cnt;
   logic             sign;
   logic             in_hs;
   logic             out_hs;
   logic             load_done;
   logic             neg_z;

   assign in_ready  = (state != EMIT);
   assign out_valid = (state == EMIT);
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   // LSB arrives first, so after WIDTH shifts it sits in shreg[0]
   assign shreg_in  = {in_bit, shreg[WIDTH-1:1]};
   assign load_done = (state == LOAD) && in_hs && (cnt == CW'(WIDTH - 1));
   assign out_last  = out_valid && (cnt == CW'(WIDTH - 1));
   assign out_sign  = out_valid && sign;
   assign out_bit   = out_valid && neg_z;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
         sign  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_hs) begin
                  shreg <= shreg_in;
                  cnt   <= CW'(1);
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (in_hs) begin
                  shreg <= shreg_in;
                  if (load_done) begin
                     sign  <= in_bit;
                     cnt   <= '0;
                     state <= EMIT;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            EMIT: begin
               if (out_hs) begin
                  shreg <= {1'b0, shreg[WIDTH-1:1]};
                  if (out_last) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   serial_negate_cell u_negate (
      .clk      (clk),
      .areset_n (areset_n),
      .clr      (load_done),
      .en       (out_hs),
      .neg      (sign),
      .b        (shreg[0]),
      .z        (neg_z)
   );

`ifdef SIGNMAG_PARALLEL_OUT_EN
   // Wrap-around negate is exact for the most-negative word when read as unsigned
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         mag_q     <= '0;
         mag_valid <= 1'b0;
      end else begin
         mag_valid <= load_done;
         if (load_done) begin
            mag_q <= in_bit ? (~shreg_in + WIDTH'(1)) : shreg_in;
         end
      end
   end
`endif

endmodule

// File: tb/tb_serial_signmag_decoder.sv
// tb/tb_serial_signmag_decoder.sv - self-checking bench for serial_signmag_decoder
module tb_serial_signmag_decoder;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] word;
      logic [W-1:0] mag;
      logic         sgn;
   } vec_t;

   logic clk = 1'b0;
   logic areset_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_bit = 1'b0;
   logic out_ready = 1'b0;
   logic in_ready, out_valid, out_bit, out_sign, out_last;
`ifdef SIGNMAG_PARALLEL_OUT_EN
   logic [W-1:0] mag_q;
   logic         mag_valid;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_signmag_decoder #(.WIDTH(W)) dut (
      .clk       (clk),
      .areset_n  (areset_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bit   (out_bit),
      .out_sign  (out_sign),
      .out_last  (out_last)
`ifdef SIGNMAG_PARALLEL_OUT_EN
      ,
      .mag_q     (mag_q),
      .mag_valid (mag_valid)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: sign and absolute value of the word read as a signed integer
   function automatic logic [W:0] model(input logic [W-1:0] w);
      int           v;
      logic [W-1:0] m;
      v = int'($signed(w));
      m = W'((v < 0) ? -v : v);
      return {v < 0, m};
   endfunction

   function automatic logic ready_pattern(input int mode, input int k);
      if (mode == 1) return (k % 3) == 0;
      if (mode == 2) return 1'($urandom_range(0, 1));
      return 1'b1;
   endfunction

   // gap_mode: 0 none, 1 alternate, 2 random; rdy_mode: 0 always, 1 pattern 1,0,0, 2 random
   task automatic run_word(input logic [W-1:0] w, input int gap_mode, input int rdy_mode,
                           output logic [W-1:0] mag, output logic sgn);
      int   sent = 0;
      int   got = 0;
      int   cyc = 0;
      int   k = 0;
      logic expect_valid = 1'b0;
      logic prev_stall = 1'b0;
      logic prev_bit = 1'b0;
      logic prev_last = 1'b0;
      logic rdy, v, b, l, s, r, go;
      logic [W:0] ref_val;
      ref_val = model(w);
      mag = '0;
      sgn = 1'b0;
      while (got < W && cyc < 400) begin
         @(negedge clk);
         cyc++;
         v = out_valid; b = out_bit; l = out_last; s = out_sign; r = in_ready;
         if (expect_valid) begin
            check("first_out_latency", v, 1);
`ifdef SIGNMAG_PARALLEL_OUT_EN
            check("mag_valid", mag_valid, 1);
            check("mag_q", mag_q, ref_val[W-1:0]);
`endif
            expect_valid = 1'b0;
         end
         rdy = ready_pattern(rdy_mode, k);
         out_ready = rdy;
         if (v) begin
            check("in_ready_low_in_emit", r, 0);
            if (prev_stall) begin
               check("stall_hold_bit", b, prev_bit);
               check("stall_hold_last", l, prev_last);
            end
            if (rdy) begin
               mag[got] = b;
               if (got == 0) sgn = s;
               else check("sign_stable", s, sgn);
               check("last_position", l, got == W - 1);
               got++;
            end
            prev_stall = !rdy;
            prev_bit = b;
            prev_last = l;
            k++;
         end else begin
            prev_stall = 1'b0;
         end
         if (r && sent < W) begin
            go = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            in_valid = go;
            in_bit = go ? w[sent] : 1'($urandom_range(0, 1));
            if (go) begin
               sent++;
               if (sent == W) expect_valid = 1'b1;
            end
         end else if (!r) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bit = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      check("word_complete", got, W);
   endtask

   task automatic feed_bits(input logic [W-1:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_bit = w[i];
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_bit"}, out_bit, 0);
      check({tag, "_out_sign"}, out_sign, 0);
      check({tag, "_out_last"}, out_last, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs[8];
      logic [W-1:0] mag, w;
      logic         sgn;
      logic [W:0]   ref_val;
      int           seen;

      vecs[0] = '{8'h05, 8'h05, 1'b0};
      vecs[1] = '{8'hFB, 8'h05, 1'b1};
      vecs[2] = '{8'h80, 8'h80, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b0};
      vecs[4] = '{8'h7F, 8'h7F, 1'b0};
      vecs[5] = '{8'hFF, 8'h01, 1'b1};
      vecs[6] = '{8'h01, 8'h01, 1'b0};
      vecs[7] = '{8'h81, 8'h7F, 1'b1};

      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      areset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_word(vecs[i].word, 0, 0, mag, sgn);
         check($sformatf("tbl%0d_mag", i), mag, vecs[i].mag);
         check($sformatf("tbl%0d_sign", i), sgn, vecs[i].sgn);
      end

      run_word(8'hFD, 1, 1, mag, sgn);
      check("m3_stall_mag", mag, 8'h03);
      check("m3_stall_sign", sgn, 1);

      // Reset in the middle of EMIT, after three emitted bits of -5
      out_ready = 1'b1;
      feed_bits(8'hFB, W);
      check("pre_reset_emit", out_valid, 1);
      repeat (3) @(posedge clk);
      #1 areset_n = 1'b0;
      #1;
      check_reset_outputs("emit_reset");
      @(negedge clk);
      areset_n = 1'b1;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         seen += int'(out_valid);
      end
      check("no_output_after_reset", seen, 0);
      run_word(8'h01, 0, 0, mag, sgn);
      check("post_reset_mag", mag, 8'h01);
      check("post_reset_sign", sgn, 0);

      // Reset in the middle of LOAD must drop the partial word
      feed_bits(8'hFF, 4);
      areset_n = 1'b0;
      #1;
      check_reset_outputs("load_reset");
      @(negedge clk);
      areset_n = 1'b1;
      run_word(8'h05, 2, 0, mag, sgn);
      check("post_load_reset_mag", mag, 8'h05);
      check("post_load_reset_sign", sgn, 0);

      for (int i = 0; i < 40; i++) begin
         w = W'($urandom);
         ref_val = model(w);
         run_word(w, $urandom_range(0, 2), 2, mag, sgn);
         check($sformatf("rnd%0d_mag_w%0h", i, w), mag, ref_val[W-1:0]);
         check($sformatf("rnd%0d_sign_w%0h", i, w), sgn, ref_val[W]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_signmag_decoder.md
SERIAL_SIGNMAG_DECODER -- requirements
Module: serial_signmag_decoder

Interface
REQ-001 Parameter WIDTH, default 8, meaning: bits per serial word; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 areset_n  input  1  reset; asynchronous and active-low.
REQ-004 in_valid  input  1  in_bit carries a valid two's-complement bit this cycle.
REQ-005 in_bit  input  1  serial two's-complement word bit, LSB first.
REQ-006 in_ready  output  1  block accepts an input bit this cycle.
REQ-007 out_valid  output  1  out_bit carries a valid magnitude bit.
REQ-008 out_ready  input  1  downstream accepts out_bit this cycle.
REQ-009 out_bit  output  1  unsigned magnitude bit, LSB first.
REQ-010 out_sign  output  1  sign of the word being emitted (1 = negative).
REQ-011 out_last  output  1  marks the final (MSB) magnitude bit of a word.

Function
REQ-012 The FSM SHALL have three states: IDLE, LOAD, EMIT.
REQ-013 An input handshake SHALL occur when in_valid and in_ready are both 1.
REQ-014 in_ready SHALL be 1 in IDLE and LOAD, and 0 in EMIT.
REQ-015 In IDLE, an input handshake SHALL store the bit, set the bit count to 1, and move to LOAD.
REQ-016 In LOAD, each handshake SHALL shift the bit into a WIDTH-bit buffer; cycles with in_valid low SHALL hold state.
REQ-017 The WIDTH-th accepted bit SHALL latch as the sign, and the FSM SHALL enter EMIT on the next edge.
REQ-018 In EMIT, out_valid SHALL be 1 and out_sign SHALL hold the latched sign.
REQ-019 Emission SHALL advance one bit per cycle in which out_valid and out_ready are both 1; otherwise out_bit, out_last and all state SHALL hold.
REQ-020 Sign 0: out_bit SHALL equal the buffered bit.
REQ-021 Sign 1: out_bit SHALL be the buffered bit until and including the first 1 bit, then the inverted buffered bit (serial negate, Mealy).
REQ-022 The negate "one-seen" flag SHALL clear at entry to EMIT.
REQ-023 out_last SHALL be 1 only on the WIDTH-th emitted bit.
REQ-024 After the out_last handshake, the FSM SHALL return to IDLE, with in_ready 1 in the next cycle.
REQ-025 Most-negative input (-2^(WIDTH-1)) SHALL emit magnitude 2^(WIDTH-1) with out_sign 1; no overflow.
REQ-026 A zero input SHALL emit all zeros with out_sign 0.
REQ-027 Input presented while in_ready is 0 SHALL be ignored and not buffered.
REQ-028 Minimum word period SHALL be 2*WIDTH cycles; the first out_valid SHALL come one cycle after the WIDTH-th input handshake.

Reset
REQ-029 areset_n low SHALL immediately force IDLE and clear the buffer, bit count, sign and one-seen flag.
REQ-030 During reset, out_valid, out_bit, out_sign and out_last SHALL be 0 and in_ready SHALL be 1.
REQ-031 Reset asserted mid-LOAD or mid-EMIT SHALL discard the partial word; no output bit SHALL follow reset release until a new full word is loaded.

Configuration
REQ-032 Macro SIGNMAG_PARALLEL_OUT_EN.
- Defined: adds output mag_q [WIDTH-1:0] (full magnitude) and mag_valid (one-cycle pulse at EMIT entry), both 0 in reset; mag_q holds until the next EMIT entry.
- Undefined: these ports do not exist.
REQ-033 Serial behaviour SHALL be identical with or without the macro.

Structure
REQ-034 Package serial_signmag_pkg SHALL hold the state enum (IDLE, LOAD, EMIT) and the WIDTH default constant.
REQ-035 The serial negate SHALL be a sub-module serial_negate_cell (ports: clk, areset_n, clr, en, neg, b, z).

Verification (WIDTH=8, out_ready=1 unless stated; values are LSB-first bit sequences)
REQ-036 +5: in 1,0,1,0,0,0,0,0 -> out 1,0,1,0,0,0,0,0; out_sign 0; out_last on 8th bit.
REQ-037 -5: in 1,1,0,1,1,1,1,1 -> out 1,0,1,0,0,0,0,0; out_sign 1.
REQ-038 -128: in 0,0,0,0,0,0,0,1 -> out 0,0,0,0,0,0,0,1; out_sign 1. Also 0 -> all zeros, out_sign 0.
REQ-039 -3 with in_valid gaps and out_ready toggling 1,0,0,1,... -> out 1,1,0,0,0,0,0,0; out_bit stable while stalled; in_valid during EMIT ignored.
REQ-040 areset_n pulsed low after the 3rd emitted bit -> outputs 0 immediately; next word +1 -> out 1,0,0,0,0,0,0,0, out_sign 0.
